// File: rtl/fpu_arb_pkg.sv
// Shared types, limits and round-robin pick for the fpu_math_arbiter slice.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 32;
  localparam int NUM_REQ_MAX   = 8;

  // Returns {found, index}: lowest set bit at or above ptr, else lowest set bit overall.
  function automatic logic [3:0] rr_pick(input logic [NUM_REQ_MAX-1:0] valid,
                                         input logic [2:0]             ptr);
    logic [NUM_REQ_MAX-1:0] hi;
    logic [3:0]             r;
    hi = valid & ({NUM_REQ_MAX{1'b1}} << ptr);
    r  = '0;
    for (int i = NUM_REQ_MAX - 1; i >= 0; i--)
      if (valid[i]) r = {1'b1, 3'(i)};
    for (int i = NUM_REQ_MAX - 1; i >= 0; i--)
      if (hi[i]) r = {1'b1, 3'(i)};
    return r;
  endfunction

endpackage

// File: rtl/fpu_math_arbiter_math_unit.sv
// Operand capture plus LAT-1 result stages; the arbiter's response register is the final stage.
// Signed-overflow flag present only with FPU_ARB_OVF_EN.
module math_unit
  import fpu_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             gt
`ifdef FPU_ARB_OVF_EN
  ,
  output logic             ovf
`endif
);

`ifdef FPU_ARB_OVF_EN
  localparam int RW = WIDTH + 2;
`else
  localparam int RW = WIDTH + 1;
`endif

  logic [WIDTH-1:0] a_q, b_q, s_c;
  logic [RW-1:0]    res_c, res_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (cap_en) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign s_c = a_q + b_q;

`ifdef FPU_ARB_OVF_EN
  assign res_c = {(a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_c[WIDTH-1] != a_q[WIDTH-1]),
                  $signed(a_q) > $signed(b_q), s_c};
`else
  assign res_c = {$signed(a_q) > $signed(b_q), s_c};
`endif

  generate
    if (LAT == 1) begin : g_comb
      assign res_out = res_c;
    end else begin : g_pipe
      logic [RW-1:0] pipe [LAT-1];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= res_c;
          for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign res_out = pipe[LAT-2];
    end
  endgenerate

  assign sum = res_out[WIDTH-1:0];
  assign gt  = res_out[WIDTH];
`ifdef FPU_ARB_OVF_EN
  assign ovf = res_out[WIDTH+1];
`endif

endmodule

// File: rtl/fpu_math_arbiter.sv
// Round-robin arbiter sharing one add/signed-compare unit; one operation in flight.
// Optional resp_ovf output enabled by FPU_ARB_OVF_EN.
//   state | meaning
//   IDLE  | arbitrate, grant combinationally, capture operands on handshake
//   EXEC  | count down datapath latency, latch result when lat_cnt hits 0
//   RESP  | hold result until resp_ready
module fpu_math_arbiter
  import fpu_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = WIDTH_DEFAULT,
  parameter  int LAT     = 1,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_gt,
`ifdef FPU_ARB_OVF_EN
  output logic                     resp_ovf,
`endif
  output logic                     busy
);

  state_t                 state, next_state;
  logic [2:0]             rr_ptr;
  logic [1:0]             lat_cnt;
  logic [NUM_REQ_MAX-1:0] valid_ext;
  logic [3:0]             pick;
  logic                   found;
  logic [2:0]             g;
  logic                   cap_en, done_en;
  logic [WIDTH-1:0]       a_sel, b_sel, mu_sum;
  logic                   mu_gt;
`ifdef FPU_ARB_OVF_EN
  logic                   mu_ovf;
`endif

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
  end

  assign pick  = rr_pick(valid_ext, rr_ptr);
  assign found = pick[3];
  assign g     = pick[2:0];

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == 3'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    next_state = state;
    cap_en     = 1'b0;
    done_en    = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          cap_en     = 1'b1;
          next_state = EXEC;
          for (int i = 0; i < NUM_REQ; i++) req_ready[i] = (g == 3'(i));
        end
      end
      EXEC: begin
        if (lat_cnt == 2'd0) begin
          done_en    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lat_cnt  <= '0;
      resp_id  <= '0;
      resp_sum <= '0;
      resp_gt  <= 1'b0;
`ifdef FPU_ARB_OVF_EN
      resp_ovf <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (cap_en) begin
        resp_id <= g[ID_W-1:0];
        rr_ptr  <= (g == 3'(NUM_REQ - 1)) ? 3'd0 : g + 3'd1;
        lat_cnt <= 2'(LAT - 1);
      end else if (state == EXEC && lat_cnt != 2'd0) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      if (done_en) begin
        resp_sum <= mu_sum;
        resp_gt  <= mu_gt;
`ifdef FPU_ARB_OVF_EN
        resp_ovf <= mu_ovf;
`endif
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  math_unit #(.WIDTH(WIDTH), .LAT(LAT)) u_math (
    .clk    (clk),
    .rst    (rst),
    .cap_en (cap_en),
    .a      (a_sel),
    .b      (b_sel),
    .sum    (mu_sum),
`ifdef FPU_ARB_OVF_EN
    .ovf    (mu_ovf),
`endif
    .gt     (mu_gt)
  );

endmodule

// File: tb/tb_fpu_math_arbiter.sv
// Self-checking bench: vector table + scoreboard on a LAT=1 instance, abort test on a LAT=4 instance.
module tb_fpu_math_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int LAT1 = 1;
  localparam int LAT4 = 4;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        gt;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst, rst4;
  logic [N-1:0]   req_valid, req_valid4, req_ready, req_ready4;
  logic [N*W-1:0] req_a, req_b, req_a4, req_b4;
  logic           resp_valid, resp_ready, resp_gt, busy;
  logic           resp_valid4, resp_ready4, resp_gt4, busy4;
  logic [1:0]     resp_id, resp_id4;
  logic [W-1:0]   resp_sum, resp_sum4;
`ifdef FPU_ARB_OVF_EN
  logic           resp_ovf, resp_ovf4;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];

  always #5 clk = ~clk;

  fpu_math_arbiter #(.NUM_REQ(N), .WIDTH(W), .LAT(LAT1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .resp_gt(resp_gt),
`ifdef FPU_ARB_OVF_EN
    .resp_ovf(resp_ovf),
`endif
    .busy(busy)
  );

  fpu_math_arbiter #(.NUM_REQ(N), .WIDTH(W), .LAT(LAT4)) dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid4), .req_a(req_a4), .req_b(req_b4),
    .req_ready(req_ready4), .resp_valid(resp_valid4), .resp_ready(resp_ready4),
    .resp_id(resp_id4), .resp_sum(resp_sum4), .resp_gt(resp_gt4),
`ifdef FPU_ARB_OVF_EN
    .resp_ovf(resp_ovf4),
`endif
    .busy(busy4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=id%0d expected=none", resp_id);
      end else begin
        mon_e = sb.pop_front();
        check("sb_id", resp_id, mon_e.id);
        check("sb_sum", resp_sum, mon_e.sum);
        check("sb_gt", resp_gt, mon_e.gt);
`ifdef FPU_ARB_OVF_EN
        check("sb_ovf", resp_ovf, mon_e.ovf);
`endif
      end
    end
  end

  task automatic issue(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e, input logic [3:0] valid_after);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'hA5A5_0000 + 32'(i);
      req_b[i*W +: W] = 32'h0F0F_0000 + 32'(i);
    end
    req_a[e.id*W +: W] = a;
    req_b[e.id*W +: W] = b;
    req_valid = valid;
    #1;
    check("grant", req_ready, 4'b0001 << e.id);
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = valid_after;
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!resp_valid && c < 20);
    check(name, c, LAT1 + 1);
  endtask

  task automatic do_op(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    issue(valid, a, b, e, 4'b0000);
    wait_valid("latency");
    @(negedge clk);
    check("busy_after_accept", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, prev, c;
    logic seen;
    exp_t e;

    vecs[0] = '{4'b0001, 32'd5,          32'd3,          '{2'd0, 32'd8,          1'b1, 1'b0}};
    vecs[1] = '{4'b0001, 32'hFFFF_FFFF,  32'd1,          '{2'd0, 32'd0,          1'b0, 1'b0}};
    vecs[2] = '{4'b0010, 32'd1,          32'hFFFF_FFFF,  '{2'd1, 32'd0,          1'b1, 1'b0}};
    vecs[3] = '{4'b1000, 32'h8000_0000,  32'h8000_0000,  '{2'd3, 32'd0,          1'b0, 1'b1}};
    vecs[4] = '{4'b1010, 32'h7FFF_FFFF,  32'd1,          '{2'd1, 32'h8000_0000,  1'b1, 1'b1}};
    vecs[5] = '{4'b0011, 32'd10,         32'd10,         '{2'd0, 32'd20,         1'b0, 1'b0}};
    vecs[6] = '{4'b0110, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  '{2'd1, 32'hFFFF_FFFD,  1'b0, 1'b0}};
    vecs[7] = '{4'b0110, 32'd3,          32'h8000_0000,  '{2'd2, 32'h8000_0003,  1'b1, 1'b0}};

    rst = 1'b1; rst4 = 1'b1;
    req_valid = '0; req_valid4 = '0;
    req_a = '0; req_b = '0; req_a4 = '0; req_b4 = '0;
    resp_ready = 1'b1; resp_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_resp_id", resp_id, 2'd0);
    check("rst_resp_sum", resp_sum, 32'd0);
    check("rst_resp_gt", resp_gt, 1'b0);
`ifdef FPU_ARB_OVF_EN
    check("rst_resp_ovf", resp_ovf, 1'b0);
`endif

    for (int i = 0; i < 8; i++) do_op(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].e);

    // Backpressure: response held 5 cycles while requester 1 waits.
    resp_ready = 1'b0;
    issue(4'b0001, 32'd100, 32'hFFFF_FF9C, '{2'd0, 32'd0, 1'b1, 1'b0}, 4'b0010);
    wait_valid("hold_latency");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", resp_valid, 1'b1);
      check("hold_id", resp_id, 2'd0);
      check("hold_sum", resp_sum, 32'd0);
      check("hold_gt", resp_gt, 1'b1);
      check("hold_no_grant", req_ready, 4'b0000);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("accept_no_grant", req_ready, 4'b0000);
    @(posedge clk);
    #1;
    req_a[1*W +: W] = 32'd7;
    req_b[1*W +: W] = 32'd9;
    sb.push_back('{2'd1, 32'd16, 1'b0, 1'b0});
    @(negedge clk);
    check("grant_after_resp", req_ready, 4'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    wait_valid("latency_after_hold");
    @(negedge clk);

    // Withdrawn request during RESP: no grant, pointer unchanged (next grant proves ptr=1).
    resp_ready = 1'b0;
    issue(4'b0001, 32'h4000_0000, 32'h4000_0000, '{2'd0, 32'h8000_0000, 1'b0, 1'b1}, 4'b0000);
    wait_valid("wd_latency");
    req_valid = 4'b0100;
    #1 check("wd_no_grant_resp", req_ready, 4'b0000);
    @(negedge clk);
    req_valid = 4'b0000;
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wd_idle_no_grant", req_ready, 4'b0000);
      check("wd_idle_busy", busy, 1'b0);
    end
    do_op(4'b0101, 32'd11, 32'd22, '{2'd2, 32'd33, 1'b0, 1'b0});

    // All requesters valid: grants 0,1,2,3,0 spaced LAT+2 cycles.
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = 32'(10 * i + 5);
      req_b[i*W +: W] = 32'(i);
    end
    req_valid = 4'b1111;
    k = 0;
    prev = 0;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        check("rr_grant", req_ready, 4'b0001 << (k % N));
        if (k > 0) check("rr_period", cyc - prev, LAT1 + 2);
        e.id  = 2'(k % N);
        e.sum = 32'(11 * (k % N) + 5);
        e.gt  = 1'b1;
        e.ovf = 1'b0;
        sb.push_back(e);
        prev = cyc;
        k++;
      end
    end
    check("rr_count", k, 5);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (LAT1 + 3) @(negedge clk);

    // Reset mid-EXEC on the LAT=4 instance.
    @(negedge clk);
    rst4 = 1'b0;
    req_a4[0 +: W] = 32'd5;
    req_b4[0 +: W] = 32'd3;
    req_valid4 = 4'b0001;
    #1 check("abort_grant", req_ready4, 4'b0001);
    @(posedge clk);
    #1 req_valid4 = '0;
    @(negedge clk);
    check("abort_busy_exec", busy4, 1'b1);
    @(posedge clk);
    #1 rst4 = 1'b1;
    @(posedge clk);
    #1 rst4 = 1'b0;
    @(negedge clk);
    check("abort_busy", busy4, 1'b0);
    check("abort_valid", resp_valid4, 1'b0);
    check("abort_ready", req_ready4, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid4) seen = 1'b1;
    end
    check("abort_no_resp", seen, 1'b0);
    req_a4[2*W +: W] = 32'hFFFF_FFF0;
    req_b4[2*W +: W] = 32'h0000_0020;
    req_valid4 = 4'b0101;
    #1 check("abort_regrant", req_ready4, 4'b0001);
    @(posedge clk);
    #1 req_valid4 = '0;
    repeat (LAT4 + 2) @(negedge clk);
    @(negedge clk);
    req_valid4 = 4'b0100;
    #1 check("lat4_grant2", req_ready4, 4'b0100);
    @(posedge clk);
    #1 req_valid4 = '0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!resp_valid4 && c < 20);
    check("lat4_latency", c, LAT4 + 1);
    check("lat4_id", resp_id4, 2'd2);
    check("lat4_sum", resp_sum4, 32'h0000_0010);
    check("lat4_gt", resp_gt4, 1'b0);
`ifdef FPU_ARB_OVF_EN
    check("lat4_ovf", resp_ovf4, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
